// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 load/store path: access sizes, LSU FSM states
// and the alignment predicate.
package riscv_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CMD    = 2'b01,
        ST_RDWAIT = 2'b10,
        ST_RESP   = 2'b11
    } lsu_state_e;

    // True when a half or word access does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/avalon_lsu_master_if.sv
// Core request/response channel plus the Avalon-MM master bus, bundled for the LSU.
interface avalon_lsu_master_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated store data on the way out,
// shifted and sign/zero-extended load data on the way back.
module lsu_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_readdata,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_writedata,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    // Lane selection and extension for the current access size.
    always_comb begin
        o_byteenable = 4'b0000;
        o_writedata  = 32'h0000_0000;
        o_load_data  = 32'h0000_0000;
        w_shifted    = i_readdata >> {i_addr_lo, 3'b000};
        case (i_size)
            SIZE_B: begin
                o_byteenable = 4'b0001 << i_addr_lo;
                o_writedata  = {4{i_wdata[7:0]}};
                if (i_unsigned) begin
                    o_load_data = {24'h00_0000, w_shifted[7:0]};
                end else begin
                    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
                end
            end
            SIZE_H: begin
                o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_writedata  = {2{i_wdata[15:0]}};
                if (i_unsigned) begin
                    o_load_data = {16'h0000, w_shifted[15:0]};
                end else begin
                    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
                end
            end
            SIZE_W: begin
                o_byteenable = 4'b1111;
                o_writedata  = i_wdata;
                o_load_data  = w_shifted;
            end
            default: begin
                o_byteenable = 4'b0000;
                o_writedata  = 32'h0000_0000;
                o_load_data  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/avalon_lsu_master.sv
// Single-outstanding Avalon-MM load/store master for the RV32 memory stage,
// with a command timeout that converts a hung slave into an error response.
module avalon_lsu_master
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    avalon_lsu_master_if.master bus
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        r_state;
    logic              r_req_ready;
    logic              r_we;
    logic [1:0]        r_size;
    logic [1:0]        r_addr_lo;
    logic              r_unsigned;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_drop_rd;
    logic              r_avm_read;
    logic              r_avm_write;
    logic [ADDR_W-1:0] r_avm_address;
    logic [3:0]        r_avm_be;
    logic [31:0]       r_avm_wdata;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;

    logic [1:0]        w_size;
    logic [1:0]        w_addr_lo;
    logic              w_unsigned;
    logic              w_illegal;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load;

    // Aligner sees the live request while idle and the latched one afterwards.
    always_comb begin
        w_size     = r_size;
        w_addr_lo  = r_addr_lo;
        w_unsigned = r_unsigned;
        if (r_state == ST_IDLE) begin
            w_size     = bus.req_size;
            w_addr_lo  = bus.req_addr[1:0];
            w_unsigned = bus.req_unsigned;
        end else begin
            w_size     = r_size;
            w_addr_lo  = r_addr_lo;
            w_unsigned = r_unsigned;
        end
        w_illegal = (bus.req_size == 2'b11) || is_misaligned(bus.req_size, bus.req_addr[1:0]);
    end

    lsu_lane_align u_align (
        .i_size       (w_size),
        .i_addr_lo    (w_addr_lo),
        .i_unsigned   (w_unsigned),
        .i_wdata      (bus.req_wdata),
        .i_readdata   (bus.avm_readdata),
        .o_byteenable (w_be),
        .o_writedata  (w_wdata),
        .o_load_data  (w_load)
    );

    // Transaction FSM; every bus and response output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_we          <= 1'b0;
            r_size        <= SIZE_B;
            r_addr_lo     <= 2'b00;
            r_unsigned    <= 1'b0;
            r_tmo         <= '0;
            r_drop_rd     <= 1'b0;
            r_avm_read    <= 1'b0;
            r_avm_write   <= 1'b0;
            r_avm_address <= '0;
            r_avm_be      <= 4'b0000;
            r_avm_wdata   <= 32'h0000_0000;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= 32'h0000_0000;
        end else begin
            // A late beat from an abandoned read is swallowed wherever it lands.
            if (bus.avm_readdatavalid && r_drop_rd) begin
                r_drop_rd <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_unsigned  <= bus.req_unsigned;
                        if (w_illegal) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                        end else begin
                            r_state       <= ST_CMD;
                            r_tmo         <= '0;
                            r_avm_read    <= ~bus.req_we;
                            r_avm_write   <= bus.req_we;
                            r_avm_address <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            r_avm_be      <= w_be;
                            r_avm_wdata   <= w_wdata;
                        end
                    end
                end
                ST_CMD: begin
                    if (!bus.avm_waitrequest) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        if (r_we) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= 32'h0000_0000;
                        end else begin
                            r_state <= ST_RDWAIT;
                            r_tmo   <= r_tmo + TMO_W'(1);
                        end
                    end else if (r_tmo >= TMO_LAST) begin
                        r_avm_read   <= 1'b0;
                        r_avm_write  <= 1'b0;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'h0000_0000;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_RDWAIT: begin
                    if (bus.avm_readdatavalid && !r_drop_rd) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load;
                    end else if (r_tmo >= TMO_LAST) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'h0000_0000;
                        r_drop_rd    <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b0;
                    r_avm_read   <= 1'b0;
                    r_avm_write  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_err       = r_resp_err;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.avm_address    = r_avm_address;
    assign bus.avm_byteenable = r_avm_be;
    assign bus.avm_read       = r_avm_read;
    assign bus.avm_write      = r_avm_write;
    assign bus.avm_writedata  = r_avm_wdata;

endmodule
